// File: rtl/dmarb_pkg.sv
// Shared definitions for the data-memory arbiter: size encodings, FSM states
// and the access alignment check.
package dmarb_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // Size 00 is malformed; halves need even addresses, words 4-byte alignment.
  function automatic logic access_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_WORD: ok = (addr_lo == 2'b00);
      SZ_HALF: ok = (addr_lo[0] == 1'b0);
      SZ_BYTE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmarb_pick.sv
// Winner selection between the two requesters. Round-robin when
// DMARB_ROUND_ROBIN_EN is defined, otherwise fixed priority to requester 0.
module dmarb_pick (
  input  logic clk,
  input  logic srst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic grant_i,
  output logic winner_o
);

`ifdef DMARB_ROUND_ROBIN_EN
  logic last_q;
  logic last_d;

  // On a tie the requester not granted last wins; pointer starts at 1.
  always_comb begin
    winner_o = req1_i & (~req0_i | ~last_q);
    last_d   = grant_i ? winner_o : last_q;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_fixed;

  assign winner_o     = ~req0_i & req1_i;
  assign unused_fixed = clk ^ srst ^ grant_i;
`endif

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter/sequencer in front of the single-port data memory.
// Build option: DMARB_ROUND_ROBIN_EN selects round-robin arbitration.
module data_memory_arbiter
  import dmarb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic [1:0]        Size0,
  input  logic [1:0]        Size1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Ack0,
  output logic              Ack1,
  output logic              Err0,
  output logic              Err1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic [1:0]        MemWrite,
  output logic [1:0]        MemRead,
  input  logic [DATA_W-1:0] MemReadData
);

  state_e            state_q, state_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic [1:0]        mwrite_q, mwrite_d;
  logic [1:0]        mread_q, mread_d;

  logic              winner;
  logic              grant;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign grant = (state_q == IDLE) && (Req0 || Req1);

  dmarb_pick u_pick (
    .clk      (Clk),
    .srst     (Reset),
    .req0_i   (Req0),
    .req1_i   (Req1),
    .grant_i  (grant),
    .winner_o (winner)
  );

  always_comb begin
    sel_we    = winner ? We1    : We0;
    sel_size  = winner ? Size1  : Size0;
    sel_addr  = winner ? Addr1  : Addr0;
    sel_wdata = winner ? WData1 : WData0;
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = '0;
    rdata1_d = '0;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwrite_d = SZ_NONE;
    mread_d  = SZ_NONE;
    case (state_q)
      IDLE: begin
        if (grant) begin
          win_d = winner;
          we_d  = sel_we;
          if (access_legal(sel_size, sel_addr[1:0])) begin
            state_d  = ACCESS;
            maddr_d  = sel_addr;
            mwdata_d = sel_wdata;
            if (sel_we) begin
              mwrite_d = sel_size;
            end else begin
              mread_d = sel_size;
            end
          end else begin
            // Rejected accesses skip the memory and answer one cycle later.
            state_d = RESP;
            ack0_d  = ~winner;
            ack1_d  = winner;
            err0_d  = ~winner;
            err1_d  = winner;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        ack0_d  = ~win_q;
        ack1_d  = win_q;
        if (!we_q) begin
          if (win_q) begin
            rdata1_d = MemReadData;
          end else begin
            rdata0_d = MemReadData;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwrite_q <= SZ_NONE;
      mread_q  <= SZ_NONE;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwrite_q <= mwrite_d;
      mread_q  <= mread_d;
    end
  end

  assign Ack0         = ack0_q;
  assign Ack1         = ack1_q;
  assign Err0         = err0_q;
  assign Err1         = err1_q;
  assign RData0       = rdata0_q;
  assign RData1       = rdata1_q;
  assign MemAddress   = maddr_q;
  assign MemWriteData = mwdata_q;
  // Reset during ACCESS must stop the store the memory would commit at this edge.
  assign MemWrite     = Reset ? SZ_NONE : mwrite_q;
  assign MemRead      = mread_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter with a behavioural 1024-word memory
// (writes on posedge, sign-extended reads on negedge).
module tb_data_memory_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic        We0 = 1'b0, We1 = 1'b0;
  logic [1:0]  Size0 = 2'b00, Size1 = 2'b00;
  logic [31:0] Addr0 = '0, Addr1 = '0;
  logic [31:0] WData0 = '0, WData1 = '0;
  logic        Ack0, Ack1, Err0, Err1;
  logic [31:0] RData0, RData1;
  logic [31:0] MemAddress, MemWriteData;
  logic [1:0]  MemWrite, MemRead;
  logic [31:0] MemReadData = '0;

  logic [31:0] mem [0:1023];

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 Clk = ~Clk;

  data_memory_arbiter dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Req0         (Req0),
    .Req1         (Req1),
    .We0          (We0),
    .We1          (We1),
    .Size0        (Size0),
    .Size1        (Size1),
    .Addr0        (Addr0),
    .Addr1        (Addr1),
    .WData0       (WData0),
    .WData1       (WData1),
    .Ack0         (Ack0),
    .Ack1         (Ack1),
    .Err0         (Err0),
    .Err1         (Err1),
    .RData0       (RData0),
    .RData1       (RData1),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemReadData  (MemReadData)
  );

  function automatic logic [31:0] mem_wr(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] res;
    res = old;
    case (sz)
      2'b01: res = wd;
      2'b10: res[16*a[1] +: 16] = wd[15:0];
      2'b11: res[8*a +: 8] = wd[7:0];
      default: res = old;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] w, input logic [1:0] sz,
                                         input logic [1:0] a);
    logic [31:0] s;
    s = w >> {a, 3'b000};
    case (sz)
      2'b10:   return {{16{s[15]}}, s[15:0]};
      2'b11:   return {{24{s[7]}}, s[7:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge Clk) begin
    if (MemWrite != 2'b00)
      mem[MemAddress[11:2]] <= mem_wr(mem[MemAddress[11:2]], MemWriteData, MemWrite, MemAddress[1:0]);
  end

  always @(negedge Clk) begin
    if (MemRead != 2'b00)
      MemReadData <= mem_rd(mem[MemAddress[11:2]], MemRead, MemAddress[1:0]);
  end

  // Response monitor: every Ack pops one expected entry.
  always @(negedge Clk) begin
    if (Ack0 || Ack1) begin
      exp_t e;
      int got;
      logic got_err;
      logic [31:0] got_rd;
      got    = Ack1 ? 1 : 0;
      got_err = Ack1 ? Err1 : Err0;
      got_rd  = Ack1 ? RData1 : RData0;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: got ack from %0d, required none", got);
      end else begin
        e = sb.pop_front();
        if (Ack0 && Ack1) begin
          bad++;
          $display("FAIL dual_ack: got both acks, required only %0d", e.id);
        end
        if (got !== e.id) begin
          bad++;
          $display("FAIL ack_id: got %0d, required %0d", got, e.id);
        end
        total++;
        if (got_err !== e.err) begin
          bad++;
          $display("FAIL err: got %0b, required %0b", got_err, e.err);
        end
        total++;
        if (got_rd !== e.rdata) begin
          bad++;
          $display("FAIL rdata: got %h, required %h", got_rd, e.rdata);
        end
        total++;
        if ((Ack1 ? {Err0, RData0} : {Err1, RData1}) !== 33'd0) begin
          bad++;
          $display("FAIL loser_zero: got err0=%b rd0=%h err1=%b rd1=%h, required loser 0",
                   Err0, RData0, Err1, RData1);
        end
        $display("txn: req%0d err=%0b rdata=%h", got, got_err, got_rd);
      end
    end
  end

  task automatic do_access(input int id, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_err, input logic [31:0] exp_rdata);
    exp_t e;
    int cycles;
    logic acked, mem_seen;
    e.id = id; e.err = exp_err; e.rdata = exp_rdata;
    sb.push_back(e);
    if (id == 0) begin
      We0 = we; Size0 = size; Addr0 = addr; WData0 = wdata; Req0 = 1'b1;
    end else begin
      We1 = we; Size1 = size; Addr1 = addr; WData1 = wdata; Req1 = 1'b1;
    end
    cycles = 0; acked = 1'b0; mem_seen = 1'b0;
    while (!acked && cycles < 8) begin
      @(posedge Clk); #1;
      cycles++;
      if (MemWrite != 2'b00 || MemRead != 2'b00) begin
        mem_seen = 1'b1;
        total++;
        if ({MemAddress, MemWriteData, MemWrite, MemRead} !==
            {addr, wdata, (we ? size : 2'b00), (we ? 2'b00 : size)}) begin
          bad++;
          $display("FAIL mem_ctrl: got addr=%h wd=%h w=%b r=%b, required addr=%h wd=%h we=%b size=%b",
                   MemAddress, MemWriteData, MemWrite, MemRead, addr, wdata, we, size);
        end
      end
      acked = (id == 0) ? Ack0 : Ack1;
    end
    Req0 = 1'b0; Req1 = 1'b0;
    total++;
    if (!acked) begin
      bad++;
      $display("FAIL ack_timeout: got no ack from req%0d, required one", id);
    end else if (cycles !== (exp_err ? 1 : 2)) begin
      bad++;
      $display("FAIL latency: got %0d, required %0d", cycles, exp_err ? 1 : 2);
    end
    total++;
    if (mem_seen !== !exp_err) begin
      bad++;
      $display("FAIL mem_activity: got %0b, required %0b", mem_seen, !exp_err);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    total++;
    if ({Ack0, Ack1, Err0, Err1, RData0, RData1, MemAddress, MemWriteData, MemWrite, MemRead} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ack=%b%b err=%b%b rd0=%h rd1=%h ma=%h mwd=%h mw=%b mr=%b, required 0",
               Ack0, Ack1, Err0, Err1, RData0, RData1, MemAddress, MemWriteData, MemWrite, MemRead);
    end
  endtask

  task automatic test_word();
    do_access(0, 1'b1, 2'b01, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    do_access(0, 1'b0, 2'b01, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
  endtask

  task automatic test_byte();
    do_access(1, 1'b1, 2'b11, 32'h13, 32'h80, 1'b0, 32'h0);
    do_access(1, 1'b0, 2'b11, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80);
    do_access(1, 1'b0, 2'b01, 32'h10, 32'h0, 1'b0, 32'h80ADBEEF);
    do_access(0, 1'b0, 2'b11, 32'h11, 32'h0, 1'b0, 32'hFFFFFFBE);
  endtask

  task automatic test_half();
    do_access(0, 1'b1, 2'b10, 32'h32, 32'h8001, 1'b0, 32'h0);
    do_access(0, 1'b0, 2'b10, 32'h32, 32'h0, 1'b0, 32'hFFFF8001);
    do_access(1, 1'b0, 2'b10, 32'h12, 32'h0, 1'b0, 32'hFFFF80AD);
    do_access(1, 1'b0, 2'b10, 32'h30, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_illegal();
    do_access(0, 1'b0, 2'b10, 32'h01, 32'h0, 1'b1, 32'h0);
    do_access(1, 1'b1, 2'b01, 32'h22, 32'h55, 1'b1, 32'h0);
    do_access(0, 1'b0, 2'b00, 32'h40, 32'h0, 1'b1, 32'h0);
    do_access(1, 1'b0, 2'b01, 32'h11, 32'h0, 1'b1, 32'h0);
  endtask

  task automatic test_reset_mid();
    We0 = 1'b1; Size0 = 2'b01; Addr0 = 32'h20; WData0 = 32'hCAFEF00D; Req0 = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b1; Req0 = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    total++;
    if ({Ack0, Ack1, Err0, Err1, RData0, RData1, MemAddress, MemWriteData, MemWrite, MemRead} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got ack=%b%b ma=%h mwd=%h mw=%b mr=%b, required 0",
               Ack0, Ack1, MemAddress, MemWriteData, MemWrite, MemRead);
    end
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if (mem[8] !== 32'h12345678) begin
      bad++;
      $display("FAIL midreset_mem: got %h, required %h", mem[8], 32'h12345678);
    end
  endtask

  task automatic test_contention();
    exp_t e;
    int acks, n0, n1, cyc;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef DMARB_ROUND_ROBIN_EN
      e.id = i % 2;
`else
      e.id = 0;
`endif
      e.err = 1'b0;
      e.rdata = (e.id == 0) ? 32'hA5A50001 : 32'h5A5A0002;
      sb.push_back(e);
    end
    We0 = 1'b0; Size0 = 2'b01; Addr0 = 32'h100; WData0 = '0;
    We1 = 1'b0; Size1 = 2'b01; Addr1 = 32'h104; WData1 = '0;
    Req0 = 1'b1; Req1 = 1'b1;
    acks = 0; n0 = 0; n1 = 0; cyc = 0;
    while (acks < 4 && cyc < 60) begin
      @(posedge Clk); #1;
      cyc++;
      if (Ack0) begin n0++; acks++; Req0 = 1'b0; end else Req0 = 1'b1;
      if (Ack1) begin n1++; acks++; Req1 = 1'b0; end else Req1 = 1'b1;
    end
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    total++;
`ifdef DMARB_ROUND_ROBIN_EN
    if (n0 !== 2 || n1 !== 2) begin
      bad++;
      $display("FAIL contention_split: got n0=%0d n1=%0d, required 2/2", n0, n1);
    end
`else
    if (n0 !== 4 || n1 !== 0) begin
      bad++;
      $display("FAIL contention_split: got n0=%0d n1=%0d, required 4/0", n0, n1);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[8]  = 32'h12345678;
    mem[64] = 32'hA5A50001;
    mem[65] = 32'h5A5A0002;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_illegal();
    test_reset_mid();
    test_contention();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL missing_acks: got %0d outstanding, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
